// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and bit-time helper.
// Used by the transmitter here and by the matching receive path.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Baud counter reload value; one line bit lasts bit_load()+1 clocks.
    function automatic int bit_load(input int fclk, input int baud);
        return fclk / baud - 1;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream valid/ready handshake into the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable bit-time down-counter: holds at zero, flags zero and mid-bit.
// Shared between the transmit and receive paths.
module uart_baud_cnt #(
    parameter int LOAD = 9,
    parameter int W    = $clog2(LOAD + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic zero_o,
    output logic mid_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = W'(LOAD);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= W'(LOAD);
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
    // Mid-bit strobe is what a receiver samples on.
    assign mid_o  = (cnt_q == W'(LOAD / 2));

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and registered serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module uart_tx
    import uart_pkg::*;
#(
    parameter int FCLK = 100000000,
    parameter int BAUD = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_tx_if.slave    bus,
    output logic        tx,
    output logic        tx_done
);

    localparam int BIT_LOAD = bit_load(FCLK, BAUD);
    localparam int CNT_W    = $clog2(BIT_LOAD + 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic                 tx_q, tx_d;
    logic                 baud_load;
    logic                 baud_zero;
    logic                 baud_mid_unused;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_baud_cnt #(
        .LOAD (BIT_LOAD),
        .W    (CNT_W)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (baud_load),
        .zero_o (baud_zero),
        .mid_o  (baud_mid_unused)
    );

    // The counter keeps running down in IDLE; only a live frame may end a bit.
    assign bit_end = baud_zero && (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        baud_load = 1'b0;
        tx_done   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    shreg_d   = bus.tx_data;
                    bitcnt_d  = '0;
                    baud_load = 1'b1;
                    state_d   = START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^bus.tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    baud_load = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                    bitcnt_d  = bitcnt_q + 3'd1;
                    baud_load = 1'b1;
                    if (bitcnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_load = 1'b1;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx stays a clean flop output.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign bus.tx_ready = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at 10 clocks per bit; driver pushes expected frames,
// a monitor process decodes the line and checks bit values and timing.
module tb_uart_tx;
    localparam int FCLK     = 1000000;
    localparam int BAUD     = 100000;
    localparam int BIT_CLKS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         hs;
        bit         full;
        int         nbits;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    logic tx, tx_done;
    int   cyc = 0;
    int   done_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_busy = 1'b0;
    item_t sb_q[$];

    uart_tx_if bus ();

    uart_tx #(.FCLK(FCLK), .BAUD(BAUD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .tx      (tx),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] b;
        b = '1;
        b[0] = 1'b0;
        b[8:1] = d;
`ifdef UART_TX_PARITY_EN
        b[9] = ^d;
`endif
        return b;
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [7:0] d, input bit hold, input bit full, input int nb);
        item_t it;
        int t;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        t = 0;
        while (bus.tx_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (bus.tx_ready !== 1'b1) begin
            chk("send_ready_timeout", 0, 1);
            bus.tx_valid = 1'b0;
        end else begin
            it.data = d; it.hs = cyc; it.full = full; it.nbits = nb;
            sb_q.push_back(it);
            @(negedge clk);
            if (!hold) bus.tx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || mon_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_idle_timeout", (sb_q.size() != 0 || mon_busy) ? 1 : 0, 0);
    endtask

    task automatic idle_check(input string nm, input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || tx_done !== 1'b0) errs++;
        end
        chk(nm, errs, 0);
    endtask

    initial begin : monitor
        forever begin
            item_t       it;
            int          t, nb, errs, derr, rerr;
            logic [10:0] bits;
            logic        exp_done;
            while (sb_q.size() == 0) @(negedge clk);
            it = sb_q.pop_front();
            mon_busy = 1'b1;
            t = 0;
            while (tx !== 1'b0 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (tx !== 1'b0) begin
                chk("start_bit_timeout", 0, 1);
            end else begin
                chk($sformatf("latency_%02h", it.data), cyc - it.hs, 1);
                bits = frame_bits(it.data);
                nb   = it.full ? NBITS : it.nbits;
                derr = 0;
                rerr = 0;
                for (int L = 0; L < nb; L++) begin
                    errs = 0;
                    for (int k = 0; k < BIT_CLKS; k++) begin
                        if (L != 0 || k != 0) @(negedge clk);
                        exp_done = (it.full && L == nb - 1 && k == BIT_CLKS - 1);
                        if (tx !== bits[L]) errs++;
                        if (tx_done !== exp_done) derr++;
                        if (bus.tx_ready !== 1'b0) rerr++;
                    end
                    chk($sformatf("frame_%02h_bit%0d", it.data, L), errs, 0);
                end
                chk($sformatf("frame_%02h_done", it.data), derr, 0);
                chk($sformatf("frame_%02h_ready_low", it.data), rerr, 0);
                if (it.full) begin
                    @(negedge clk);
                    chk($sformatf("frame_%02h_ready_after", it.data),
                        (bus.tx_ready === 1'b1 && tx === 1'b1) ? 1 : 0, 1);
                end
            end
            mon_busy = 1'b0;
        end
    end

    initial begin : driver
        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_ready", bus.tx_ready, 1);
        chk("reset_done", tx_done, 0);
        rst_n = 1'b1;
        idle_check("idle_no_stim", 40);

        send(8'h55, 1'b0, 1'b1, NBITS);
        wait_idle();

        // Back-to-back: second byte accepted on the IDLE cycle after tx_done.
        send(8'hA5, 1'b1, 1'b1, NBITS);
        send(8'h3C, 1'b0, 1'b1, NBITS);
        wait_idle();

        send(8'h5A, 1'b0, 1'b1, NBITS);
        repeat (20) @(negedge clk);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        wait_idle();
        idle_check("idle_after_ignored_req", 30);

        // Reset in the middle of data bit 4 (a 0 bit for 0x0F).
        send(8'h0F, 1'b0, 1'b0, 5);
        repeat (54) @(negedge clk);
        chk("pre_reset_tx_low", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("reset_midframe_tx", tx, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_check("idle_after_reset", 20);
        send(8'h81, 1'b0, 1'b1, NBITS);
        wait_idle();

        send(8'h07, 1'b0, 1'b1, NBITS);
        wait_idle();
        send(8'h03, 1'b0, 1'b1, NBITS);
        wait_idle();

        chk("tx_done_total", done_cnt, 7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
